phy_clk_seq: RTL and testbench

Startup and recovery sequencer for the DDR3 PHY clocking resources. Drives the clock generator MMCM reset, waits for `locked`, qualifies lock stability, then sequences IDELAYCTRL and ISERDES/OSERDES resets before asserting `phy_ready` to calibration logic. It runs on the reference clock, which is live before the MMCM locks. It retries on lock timeout and restarts on lock loss.

---
 rtl/phy_pkg.sv | 26 ++
 rtl/sync2.sv | 24 ++
 rtl/phy_clk_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_phy_clk_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared types and default timing for the DDR3 PHY clock startup sequencer.
// State encodings are fixed so debug tools can decode the state output directly.
package phy_pkg;

  typedef enum logic [2:0] {
    ST_MMCM_RST   = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_IDLY_RST   = 3'd3,
    ST_IDLY_WAIT  = 3'd4,
    ST_SERDES_RST = 3'd5,
    ST_READY      = 3'd6,
    ST_ERROR      = 3'd7
  } phy_clk_seq_state_t;

  localparam int unsigned DEF_MMCM_RST_CYCLES   = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT      = 4096;
  localparam int unsigned DEF_STABLE_CYCLES     = 256;
  localparam int unsigned DEF_SERDES_RST_CYCLES = 32;
  localparam int unsigned DEF_MAX_RETRIES       = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for single-bit asynchronous status inputs, resets to 0.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/phy_clk_seq.sv
// Startup/recovery sequencer for DDR3 PHY clocking: MMCM reset, lock qualification,
// IDELAYCTRL and SERDES reset sequencing, retry on timeout and restart on lock loss.
module phy_clk_seq
  import phy_pkg::*;
#(
  parameter int unsigned MMCM_RST_CYCLES   = DEF_MMCM_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT      = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES     = DEF_STABLE_CYCLES,
  parameter int unsigned SERDES_RST_CYCLES = DEF_SERDES_RST_CYCLES,
  parameter int unsigned MAX_RETRIES       = DEF_MAX_RETRIES
) (
  input  logic                                   clkin,
  input  logic                                   reset_n,
  input  logic                                   restart,
  input  logic                                   locked,
  input  logic                                   idelay_rdy,
  output logic                                   mmcm_reset,
  output logic                                   idelayctrl_reset,
  output logic                                   serdes_reset,
  output logic                                   phy_ready,
  output logic                                   error,
  output logic                                   lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]       retry_count,
  output logic [2:0]                             state
);

  localparam int unsigned CNT_MAX = max_u(max_u(MMCM_RST_CYCLES, LOCK_TIMEOUT),
                                          max_u(STABLE_CYCLES, SERDES_RST_CYCLES));
  localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  phy_clk_seq_state_t r_state;
  phy_clk_seq_state_t w_next;
  logic [CW-1:0]      r_cnt;
  logic               w_cnt_zero;
  logic               w_enter;
  logic               w_fail;
  logic [RW-1:0]      r_retry;
  logic [RW-1:0]      w_retry_inc;

  logic w_locked_s;
  logic w_idelay_rdy_s;

  logic w_mmcm_rst;
  logic w_idly_rst;
  logic w_serdes_rst;
  logic w_phy_ready;
  logic w_error;
  logic w_lock_lost;

  logic r_mmcm_rst;
  logic r_idly_rst;
  logic r_serdes_rst;
  logic r_phy_ready;
  logic r_error;
  logic r_lock_lost;

  sync2 u_sync_locked (
    .i_clk   (clkin),
    .i_rst_n (reset_n),
    .i_d     (locked),
    .o_q     (w_locked_s)
  );

  sync2 u_sync_idelay_rdy (
    .i_clk   (clkin),
    .i_rst_n (reset_n),
    .i_d     (idelay_rdy),
    .o_q     (w_idelay_rdy_s)
  );

  // Count loaded on entry so that a state lasts exactly N cycles before cnt hits 0.
  function automatic logic [CW-1:0] reload(input phy_clk_seq_state_t s);
    case (s)
      ST_MMCM_RST:   reload = CW'(MMCM_RST_CYCLES - 1);
      ST_WAIT_LOCK:  reload = CW'(LOCK_TIMEOUT - 1);
      ST_STABLE:     reload = CW'(STABLE_CYCLES - 1);
      ST_IDLY_RST:   reload = CW'(SERDES_RST_CYCLES - 1);
      ST_IDLY_WAIT:  reload = CW'(LOCK_TIMEOUT - 1);
      ST_SERDES_RST: reload = CW'(SERDES_RST_CYCLES - 1);
      default:       reload = '0;
    endcase
  endfunction

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_retry_inc = r_retry + RW'(1);
  assign w_enter     = restart || (w_next != r_state);

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_MMCM_RST;
      r_cnt   <= CW'(MMCM_RST_CYCLES - 1);
    end else begin
      r_state <= w_next;
      if (w_enter) begin
        r_cnt <= reload(w_next);
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_fail = 1'b0;
    if (restart) begin
      w_next = ST_MMCM_RST;
    end else begin
      case (r_state)
        ST_MMCM_RST: begin
          if (w_cnt_zero) w_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s)      w_next = ST_STABLE;
          else if (w_cnt_zero) w_fail = 1'b1;
        end
        ST_STABLE: begin
          if (!w_locked_s)     w_next = ST_WAIT_LOCK;
          else if (w_cnt_zero) w_next = ST_IDLY_RST;
        end
        ST_IDLY_RST: begin
          if (w_cnt_zero) w_next = ST_IDLY_WAIT;
        end
        ST_IDLY_WAIT: begin
          if (!w_locked_s)         w_next = ST_WAIT_LOCK;
          else if (w_idelay_rdy_s) w_next = ST_SERDES_RST;
          else if (w_cnt_zero)     w_fail = 1'b1;
        end
        ST_SERDES_RST: begin
          if (w_cnt_zero) w_next = ST_READY;
        end
        ST_READY: begin
          if (!w_locked_s) w_next = ST_MMCM_RST;
        end
        ST_ERROR: begin
          w_next = ST_ERROR;
        end
        default: begin
          w_next = ST_MMCM_RST;
        end
      endcase
      if (w_fail) begin
        w_next = (w_retry_inc == RW'(MAX_RETRIES)) ? ST_ERROR : ST_MMCM_RST;
      end
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_retry <= '0;
    end else if (restart) begin
      r_retry <= '0;
    end else if (w_fail) begin
      r_retry <= w_retry_inc;
    end else if ((r_state == ST_SERDES_RST) && (w_next == ST_READY)) begin
      r_retry <= '0;
    end
  end

  // Outputs are decoded from the next state and registered, so they change on the entry edge.
  always_comb begin
    w_mmcm_rst   = 1'b0;
    w_idly_rst   = 1'b0;
    w_serdes_rst = 1'b1;
    w_phy_ready  = 1'b0;
    w_error      = 1'b0;
    case (w_next)
      ST_MMCM_RST: begin
        w_mmcm_rst = 1'b1;
        w_idly_rst = 1'b1;
      end
      ST_WAIT_LOCK, ST_STABLE, ST_IDLY_RST: begin
        w_idly_rst = 1'b1;
      end
      ST_IDLY_WAIT, ST_SERDES_RST: begin
        w_idly_rst = 1'b0;
      end
      ST_READY: begin
        w_serdes_rst = 1'b0;
        w_phy_ready  = 1'b1;
      end
      ST_ERROR: begin
        w_mmcm_rst = 1'b1;
        w_idly_rst = 1'b1;
        w_error    = 1'b1;
      end
      default: begin
        w_mmcm_rst = 1'b1;
        w_idly_rst = 1'b1;
      end
    endcase
    w_lock_lost = (r_state == ST_READY) && !w_locked_s && !restart;
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_mmcm_rst   <= 1'b1;
      r_idly_rst   <= 1'b1;
      r_serdes_rst <= 1'b1;
      r_phy_ready  <= 1'b0;
      r_error      <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_mmcm_rst   <= w_mmcm_rst;
      r_idly_rst   <= w_idly_rst;
      r_serdes_rst <= w_serdes_rst;
      r_phy_ready  <= w_phy_ready;
      r_error      <= w_error;
      r_lock_lost  <= w_lock_lost;
    end
  end

  assign mmcm_reset       = r_mmcm_rst;
  assign idelayctrl_reset = r_idly_rst;
  assign serdes_reset     = r_serdes_rst;
  assign phy_ready        = r_phy_ready;
  assign error            = r_error;
  assign lock_lost        = r_lock_lost;
  assign retry_count      = r_retry;
  assign state            = r_state;

endmodule

// File: tb/tb_phy_clk_seq.sv
// Self-checking bench for phy_clk_seq: a behavioural MMCM/IDELAYCTRL plant reacts to the
// reset outputs; timings are checked against cycle counts derived from the parameters.
module tb_phy_clk_seq;
  import phy_pkg::*;

  localparam int P_MMCM   = 4;
  localparam int P_STABLE = 8;
  localparam int P_SERDES = 4;
  localparam int P_TO     = 32;
  localparam int P_MAXR   = 3;
  localparam int RW       = $clog2(P_MAXR + 1);
  // reset release to READY with lock/rdy arriving immediately, and to IDELAYCTRL release
  localparam int T_BASE   = P_MMCM + 3 + P_STABLE + P_SERDES + 3 + P_SERDES;
  localparam int T_IFALL  = P_MMCM + 3 + P_STABLE + P_SERDES;

  logic clkin = 1'b0;
  logic reset_n = 1'b0;
  logic restart = 1'b0;
  logic locked = 1'b0;
  logic idelay_rdy = 1'b0;
  logic mmcm_reset, idelayctrl_reset, serdes_reset, phy_ready, error, lock_lost;
  logic [RW-1:0] retry_count;
  logic [2:0] state;

  phy_clk_seq #(
    .MMCM_RST_CYCLES   (P_MMCM),
    .LOCK_TIMEOUT      (P_TO),
    .STABLE_CYCLES     (P_STABLE),
    .SERDES_RST_CYCLES (P_SERDES),
    .MAX_RETRIES       (P_MAXR)
  ) dut (
    .clkin            (clkin),
    .reset_n          (reset_n),
    .restart          (restart),
    .locked           (locked),
    .idelay_rdy       (idelay_rdy),
    .mmcm_reset       (mmcm_reset),
    .idelayctrl_reset (idelayctrl_reset),
    .serdes_reset     (serdes_reset),
    .phy_ready        (phy_ready),
    .error            (error),
    .lock_lost        (lock_lost),
    .retry_count      (retry_count),
    .state            (state)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    string name;
    int    lk;
    int    rd;
    int    g_at;
    int    g_len;
    int    exp_rdy;
    int    exp_if;
  } vec_t;

  typedef struct {
    string name;
    int    rdy;
    int    mf;
    int    ifall;
    int    falls;
  } exp_t;

  vec_t vecs[4];
  exp_t sb_q[$];
  exp_t ex;

  int checks = 0;
  int errors = 0;

  // plant configuration and state (lk/rd < 0 means never asserts)
  int lk_dly, rd_dly, g_at, g_len, drop_at;
  int lk_cnt, rd_cnt, cyc;
  bit drop;
  // monitors
  int t_mf, t_if, t_sf, t_rdy, t_err, n_mfalls, n_mlow, n_ll;
  bit prev_m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_plant(input int lk, input int rd, input int ga, input int gl, input int da);
    lk_dly = lk; rd_dly = rd; g_at = ga; g_len = gl; drop_at = da;
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
    cyc++;
    if (prev_m && !mmcm_reset) n_mfalls++;
    prev_m = mmcm_reset;
    if (!mmcm_reset) n_mlow++;
    if (!mmcm_reset && t_mf == 0) t_mf = cyc;
    if (!idelayctrl_reset && t_if == 0) t_if = cyc;
    if (!serdes_reset && t_sf == 0) t_sf = cyc;
    if (phy_ready && t_rdy == 0) t_rdy = cyc;
    if (error && t_err == 0) t_err = cyc;
    if (lock_lost) n_ll++;
    if (mmcm_reset) begin
      lk_cnt = 0;
      drop = 1'b0;
    end else begin
      lk_cnt++;
    end
    if (cyc == drop_at) drop = 1'b1;
    locked = !mmcm_reset && (lk_dly >= 0) && (lk_cnt > lk_dly) && !drop &&
             !((cyc >= g_at) && (cyc < g_at + g_len));
    if (idelayctrl_reset) rd_cnt = 0;
    else rd_cnt++;
    idelay_rdy = !idelayctrl_reset && (rd_dly >= 0) && (rd_cnt > rd_dly);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; restart = 1'b0; locked = 1'b0; idelay_rdy = 1'b0;
    lk_cnt = 0; rd_cnt = 0; drop = 1'b0; cyc = 0; prev_m = 1'b1;
    t_mf = 0; t_if = 0; t_sf = 0; t_rdy = 0; t_err = 0;
    n_mfalls = 0; n_mlow = 0; n_ll = 0;
    repeat (3) @(posedge clkin);
    #1 reset_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " mmcm_reset"}, int'(mmcm_reset), 1);
    chk({tag, " idelayctrl_reset"}, int'(idelayctrl_reset), 1);
    chk({tag, " serdes_reset"}, int'(serdes_reset), 1);
    chk({tag, " phy_ready"}, int'(phy_ready), 0);
    chk({tag, " error"}, int'(error), 0);
    chk({tag, " lock_lost"}, int'(lock_lost), 0);
    chk({tag, " retry_count"}, int'(retry_count), 0);
    chk({tag, " state"}, int'(state), int'(ST_MMCM_RST));
  endtask

  initial begin
    int base;
    int d;

    vecs[0] = '{"nominal", 10, 5, -1, 0, T_BASE + 15, T_IFALL + 10};
    vecs[1] = '{"ideal",    0, 0, -1, 0, T_BASE,      T_IFALL};
    vecs[2] = '{"glitch",  10, 5, 20, 2, T_BASE + 15 + 8, T_IFALL + 10 + 8};
    vecs[3] = '{"alt",      3, 7, -1, 0, T_BASE + 10, T_IFALL + 3};

    set_plant(-1, -1, -1, 0, -1);
    repeat (2) @(posedge clkin);
    #1;
    chk_reset_vals("por");

    foreach (vecs[i]) begin
      exp_t e;
      set_plant(vecs[i].lk, vecs[i].rd, vecs[i].g_at, vecs[i].g_len, -1);
      do_reset();
      e.name = vecs[i].name; e.rdy = vecs[i].exp_rdy; e.mf = P_MMCM;
      e.ifall = vecs[i].exp_if; e.falls = 1;
      sb_q.push_back(e);
      for (int k = 0; k < 200 && t_rdy == 0 && t_err == 0; k++) tick();
      ex = sb_q.pop_front();
      chk({ex.name, " ready cycle"}, t_rdy, ex.rdy);
      chk({ex.name, " mmcm release"}, t_mf, ex.mf);
      chk({ex.name, " idelayctrl release"}, t_if, ex.ifall);
      chk({ex.name, " serdes release"}, t_sf, ex.rdy);
      chk({ex.name, " mmcm pulses"}, n_mfalls, ex.falls);
      chk({ex.name, " retry_count"}, int'(retry_count), 0);
      chk({ex.name, " state"}, int'(state), int'(ST_READY));
      chk({ex.name, " error"}, int'(error), 0);
    end

    // lock never asserts: three attempts then ERROR, then restart recovers
    set_plant(-1, 5, -1, 0, -1);
    do_reset();
    for (int k = 0; k < 300 && t_err == 0; k++) tick();
    chk("nolock error cycle", t_err, P_MAXR * (P_MMCM + P_TO));
    chk("nolock retry_count", int'(retry_count), P_MAXR);
    chk("nolock state", int'(state), int'(ST_ERROR));
    chk("nolock mmcm pulses", n_mfalls, P_MAXR);
    chk("nolock gap cycles", n_mlow, P_MAXR * P_TO);
    chk("nolock mmcm_reset", int'(mmcm_reset), 1);
    chk("nolock serdes_reset", int'(serdes_reset), 1);
    repeat (4) tick();
    chk("nolock error sticky", int'(error), 1);
    set_plant(10, 5, -1, 0, -1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    base = cyc;
    chk("restart error cleared", int'(error), 0);
    chk("restart retry cleared", int'(retry_count), 0);
    chk("restart state", int'(state), int'(ST_MMCM_RST));
    for (int k = 0; k < 200 && t_rdy == 0; k++) tick();
    chk("restart ready cycle", t_rdy - base, T_BASE + 15);

    // lock lost in READY
    d = 50;
    set_plant(10, 5, -1, 0, d);
    do_reset();
    for (int k = 0; k < 100 && cyc < d + 2; k++) tick();
    chk("lost ready before", int'(phy_ready), 1);
    chk("lost pulse early", int'(lock_lost), 0);
    tick();
    chk("lost cycle", cyc, d + 3);
    chk("lost pulse", int'(lock_lost), 1);
    chk("lost phy_ready", int'(phy_ready), 0);
    chk("lost serdes_reset", int'(serdes_reset), 1);
    chk("lost state", int'(state), int'(ST_MMCM_RST));
    tick();
    chk("lost pulse width", int'(lock_lost), 0);
    for (int k = 0; k < 200 && !phy_ready; k++) tick();
    chk("lost re-ready cycle", cyc, d + 3 + T_BASE + 15);
    chk("lost pulse count", n_ll, 1);
    chk("lost retry_count", int'(retry_count), 0);

    // idelay_rdy stuck low
    set_plant(10, -1, -1, 0, -1);
    do_reset();
    for (int k = 0; k < 200 && cyc < T_IFALL + 10 + P_TO - 1; k++) tick();
    chk("stuck state before", int'(state), int'(ST_IDLY_WAIT));
    chk("stuck retry before", int'(retry_count), 0);
    tick();
    chk("stuck retry_count", int'(retry_count), 1);
    chk("stuck mmcm_reset", int'(mmcm_reset), 1);
    chk("stuck state", int'(state), int'(ST_MMCM_RST));

    // reset_n asserted during SERDES reset hold
    set_plant(10, 5, -1, 0, -1);
    do_reset();
    for (int k = 0; k < 200 && cyc < T_IFALL + 10 + 5 + 3 + 1; k++) tick();
    chk("midrst state", int'(state), int'(ST_SERDES_RST));
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    do_reset();
    for (int k = 0; k < 200 && t_rdy == 0; k++) tick();
    chk("midrst ready cycle", t_rdy, T_BASE + 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
